uart_fifo_ctrl: RTL and testbench

//  Memory-mapped UART with parametrised frame format, TX/RX FIFOs, 16x oversampled RX and a level IRQ.

---
 rtl/uart_fifo_ctrl_if.sv | 11 +
 rtl/uart_fifo_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_ctrl_if.sv
// Peripheral-bus view of the UART: one-cycle rd/wr strobes and a combinational read-data return.
interface uart_fifo_ctrl_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, wr, addr, wdata, input rdata);
    modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART: TX/RX FIFOs, configurable frame, 16x oversampled receiver, sticky errors, level IRQ.
// The small synchronous FIFO used by both channels lives in this file as well.
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

module uart_fifo_ctrl #(
    parameter int          CLK_HZ     = 50000000,
    parameter int          BAUD       = 9600,
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h40000018
) (
    input  logic              sysclk,
    input  logic              reset,
    uart_fifo_ctrl_if.slave   bus,
    input  logic              rxd_i,
    output logic              txd_o,
    output logic              irq_o
);
    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

    logic [DW-1:0]        baud_cnt_q;
    logic                 tick;
    logic [5:0]           ctrl_q;
    logic                 ovr_q, ferr_q, perr_q, irq_q;
    logic                 sel_tx, sel_rx, sel_cs, cs_wr;
    logic [2:0]           w1c;
    logic [31:0]          rdata_d;
    logic                 unused_wdata;

    logic                 tx_full, tx_empty, tx_pop, tx_bit_end;
    logic [DATA_BITS-1:0] tx_head;
    tx_state_t            tx_state_q;
    logic [3:0]           tx_cnt_q;
    logic [BW-1:0]        tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q, tx_pen_q, txd_q;

    logic                 rx_full, rx_empty, rx_pop, rx_smp;
    logic [DATA_BITS-1:0] rx_head;
    rx_state_t            rx_state_q;
    logic [1:0]           rx_sync_q;
    logic                 rxd_s;
    logic [3:0]           rx_cnt_q;
    logic [BW-1:0]        rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_q, rx_push_q, ferr_set_q, perr_set_q;

    wire ctrl_tx_en   = ctrl_q[0];
    wire ctrl_rx_en   = ctrl_q[1];
    wire ctrl_irq_txe = ctrl_q[2];
    wire ctrl_irq_rx  = ctrl_q[3];
    wire ctrl_par_en  = ctrl_q[4];
    wire ctrl_par_odd = ctrl_q[5];
    wire tx_busy      = (tx_state_q != TX_IDLE);

    assign sel_tx       = (bus.addr == BASE_ADDR);
    assign sel_rx       = (bus.addr == BASE_ADDR + 32'd4);
    assign sel_cs       = (bus.addr == BASE_ADDR + 32'd8);
    assign cs_wr        = bus.wr & sel_cs;
    assign w1c          = cs_wr ? bus.wdata[15:13] : 3'b000;
    assign rx_pop       = bus.rd & sel_rx;
    assign unused_wdata = ^bus.wdata;

    uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(sysclk), .rst_n(reset), .push_i(bus.wr & sel_tx), .pop_i(tx_pop),
        .wdata_i(bus.wdata[DATA_BITS-1:0]), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(sysclk), .rst_n(reset), .push_i(rx_push_q), .pop_i(rx_pop),
        .wdata_i(rx_shift_q), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign tick = (baud_cnt_q == DW'(DIV - 1));

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) baud_cnt_q <= '0;
        else        baud_cnt_q <= tick ? '0 : baud_cnt_q + 1'b1;
    end

    // A pop at the end of STOP chains straight into the next START, so frames abut with one stop bit.
    assign tx_bit_end = tick & (tx_cnt_q == 4'd15);
    assign tx_pop     = ctrl_tx_en & ~tx_empty &
                        ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & tx_bit_end));

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else if (tx_pop) begin
            tx_state_q <= TX_START;
            tx_cnt_q   <= '0;
            tx_shift_q <= tx_head;
            tx_par_q   <= ^tx_head ^ ctrl_par_odd;
            tx_pen_q   <= ctrl_par_en;
            txd_q      <= 1'b0;
        end else if (tx_busy && tick) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_bit_end) begin
                unique case (tx_state_q)
                    TX_START: begin
                        tx_state_q <= TX_DATA;
                        tx_bit_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                    end
                    TX_DATA: begin
                        if (tx_bit_q == LAST_BIT) begin
                            tx_state_q <= tx_pen_q ? TX_PARITY : TX_STOP;
                            txd_q      <= tx_pen_q ? tx_par_q : 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            txd_q      <= tx_shift_q[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state_q <= TX_STOP;
                        txd_q      <= 1'b1;
                    end
                    default: begin
                        tx_state_q <= TX_IDLE;
                        txd_q      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rxd_s  = rx_sync_q[1];
    assign rx_smp = tick & (rx_cnt_q == 4'd15);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_push_q  <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rxd_i};
            rx_push_q  <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
            if ((rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT) && tick) rx_cnt_q <= rx_cnt_q + 1'b1;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (ctrl_rx_en && !rxd_s) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // Half-bit resample; a line back high here was only a glitch.
                    if (tick && rx_cnt_q == 4'd7) begin
                        rx_state_q <= rxd_s ? RX_IDLE : RX_DATA;
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_par_q   <= 1'b0;
                    end
                end
                RX_DATA: begin
                    if (rx_smp) begin
                        rx_shift_q <= {rxd_s, rx_shift_q[DATA_BITS-1:1]};
                        rx_par_q   <= rx_par_q ^ rxd_s;
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == LAST_BIT) rx_state_q <= ctrl_par_en ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (rx_smp) begin
                        perr_set_q <= (rx_par_q ^ ctrl_par_odd) != rxd_s;
                        rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_smp) begin
                        rx_push_q  <= rxd_s;
                        ferr_set_q <= ~rxd_s;
                        rx_state_q <= rxd_s ? RX_IDLE : RX_WAIT;
                    end
                end
                default: begin
                    if (rxd_s) rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (cs_wr) ctrl_q <= bus.wdata[5:0];
            ovr_q  <= (ovr_q  & ~w1c[0]) | (rx_push_q & rx_full);
            ferr_q <= (ferr_q & ~w1c[1]) | ferr_set_q;
            perr_q <= (perr_q & ~w1c[2]) | perr_set_q;
            irq_q  <= (ctrl_irq_rx & ~rx_empty) | (ctrl_irq_txe & tx_empty & ~tx_busy);
        end
    end

    always_comb begin
        rdata_d = '0;
        if (bus.rd) begin
            if (sel_rx && !rx_empty)
                rdata_d = 32'(rx_head);
            else if (sel_cs)
                rdata_d = {16'b0, perr_q, ferr_q, ovr_q, tx_busy, rx_empty, rx_full,
                           tx_empty, tx_full, 2'b00, ctrl_q};
        end
    end

    assign bus.rdata = rdata_d;
    assign txd_o     = txd_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: loopback frames, FIFO limits, error reporting, reset abort, IRQ.
module tb_uart_fifo_ctrl;
    localparam logic [31:0] A_TX = 32'h40000018;
    localparam logic [31:0] A_RX = 32'h4000001C;
    localparam logic [31:0] A_CS = 32'h40000020;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loop_en = 1'b0;
    logic rxd_drv = 1'b1;
    logic txd, irq, rxd;
    int   n_checks = 0;
    int   n_fail = 0;

    uart_fifo_ctrl_if bus ();

    assign rxd = loop_en ? txd : rxd_drv;

    uart_fifo_ctrl #(
        .CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .FIFO_DEPTH(4), .BASE_ADDR(32'h40000018)
    ) dut (
        .sysclk(clk), .reset(rst_n), .bus(bus), .rxd_i(rxd), .txd_o(txd), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.rd = 1'b1; bus.addr = a;
        #1 d = bus.rdata;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; loop_en = 1'b0; rxd_drv = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Samples nbits line bits (start first) near bit centres, starting from the next falling edge.
    task automatic tx_capture(input int nbits, input int budget, output logic [15:0] bits,
                              output int waited, output bit got);
        bits = '0; waited = 0; got = 1'b0;
        while (txd !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (txd !== 1'b0) return;
        got = 1'b1;
        repeat (75) @(negedge clk);
        bits[0] = txd;
        for (int i = 1; i < nbits; i++) begin
            repeat (160) @(negedge clk);
            bits[i] = txd;
        end
    endtask

    task automatic send_rx(input logic [7:0] data, input bit with_par, input logic par, input logic stop);
        rxd_drv = 1'b0;
        wait_clk(160);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = data[i];
            wait_clk(160);
        end
        if (with_par) begin
            rxd_drv = par;
            wait_clk(160);
        end
        rxd_drv = stop;
        wait_clk(160);
        rxd_drv = 1'b1;
    endtask

    logic [31:0] rd;
    logic [15:0] bits;
    int          waited;
    bit          got;
    logic [7:0]  exp2 [4];

    initial begin
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        exp2 = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();

        // Reset state
        check_eq("rst txd", 32'(txd), 32'd1);
        check_eq("rst irq", 32'(irq), 32'd0);
        bus_rd(A_CS, rd); check_eq("rst stat", rd, 32'h0A00);
        bus_rd(A_RX, rd); check_eq("rst rxdata empty", rd, 32'h0);
        bus_rd(A_TX, rd); check_eq("rst txdata read", rd, 32'h0);

        // 1: loopback 0xA5
        loop_en = 1'b1;
        bus_wr(A_CS, 32'h03);
        bus_wr(A_TX, 32'hA5);
        tx_capture(10, 500, bits, waited, got);
        check_eq("t1 got frame", 32'(got), 32'd1);
        check_eq("t1 frame bits", 32'(bits), 32'({1'b1, 8'hA5, 1'b0}));
        wait_clk(200);
        bus_rd(A_CS, rd); check_eq("t1 rx not empty", 32'(rd[11]), 32'd0);
        bus_rd(A_RX, rd); check_eq("t1 rxdata", rd, 32'hA5);
        bus_rd(A_CS, rd); check_eq("t1 stat after", rd, 32'h0A03);

        // 2: fill TX FIFO with tx disabled, then release
        do_reset();
        for (int i = 0; i < 4; i++) bus_wr(A_TX, 32'h11 * (i + 1));
        bus_rd(A_CS, rd); check_eq("t2 tx full", rd, 32'h0900);
        bus_wr(A_TX, 32'h55);
        bus_wr(A_CS, 32'h01);
        for (int k = 0; k < 4; k++) begin
            tx_capture(10, 500, bits, waited, got);
            check_eq($sformatf("t2 got frame %0d", k), 32'(got), 32'd1);
            check_eq($sformatf("t2 frame %0d", k), 32'(bits), 32'({1'b1, exp2[k], 1'b0}));
            if (k > 0) check_eq($sformatf("t2 gap ok %0d", k), 32'(waited <= 95), 32'd1);
        end
        tx_capture(10, 2000, bits, waited, got);
        check_eq("t2 no fifth frame", 32'(got), 32'd0);
        bus_rd(A_CS, rd); check_eq("t2 stat idle", rd, 32'h0A01);

        // 3: RX overrun
        do_reset();
        loop_en = 1'b1;
        bus_wr(A_CS, 32'h03);
        for (int i = 1; i <= 5; i++) bus_wr(A_TX, 32'(i));
        wait_clk(9200);
        bus_rd(A_CS, rd); check_eq("t3 stat full ovr", rd, 32'h2603);
        for (int i = 1; i <= 4; i++) begin
            bus_rd(A_RX, rd); check_eq($sformatf("t3 rx byte %0d", i), rd, 32'(i));
        end
        bus_rd(A_CS, rd); check_eq("t3 stat drained", rd, 32'h2A03);
        bus_wr(A_CS, 32'h2000);
        bus_rd(A_CS, rd); check_eq("t3 ovr cleared", rd, 32'h0A00);

        // 4: framing error, then a short glitch
        do_reset();
        bus_wr(A_CS, 32'h02);
        send_rx(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clk(300);
        bus_rd(A_CS, rd); check_eq("t4 frame err", rd, 32'h4A02);
        bus_wr(A_CS, 32'h4002);
        bus_rd(A_CS, rd); check_eq("t4 ferr cleared", rd, 32'h0A02);
        rxd_drv = 1'b0; wait_clk(40); rxd_drv = 1'b1;
        wait_clk(400);
        bus_rd(A_CS, rd); check_eq("t4 glitch ignored", rd, 32'h0A02);

        // 5: odd parity
        do_reset();
        loop_en = 1'b1;
        bus_wr(A_CS, 32'h33);
        bus_wr(A_TX, 32'h01);
        tx_capture(11, 500, bits, waited, got);
        check_eq("t5 got frame", 32'(got), 32'd1);
        check_eq("t5 frame bits", 32'(bits), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
        wait_clk(200);
        bus_rd(A_RX, rd); check_eq("t5 rx good", rd, 32'h01);
        bus_rd(A_CS, rd); check_eq("t5 no perr", rd, 32'h0A33);
        loop_en = 1'b0;
        send_rx(8'h03, 1'b1, 1'b0, 1'b1);
        wait_clk(300);
        bus_rd(A_CS, rd); check_eq("t5 perr", rd, 32'h8233);
        bus_rd(A_RX, rd); check_eq("t5 rx bad par byte", rd, 32'h03);

        // 6: reset in the middle of a TX frame
        do_reset();
        loop_en = 1'b1;
        bus_wr(A_CS, 32'h03);
        bus_wr(A_TX, 32'h5A);
        bus_wr(A_TX, 32'h77);
        waited = 0;
        while (txd !== 1'b0 && waited < 500) begin @(negedge clk); waited++; end
        check_eq("t6 frame started", 32'(txd), 32'd0);
        wait_clk(400);
        rst_n = 1'b0;
        #1 check_eq("t6 async txd", 32'(txd), 32'd1);
        wait_clk(3);
        rst_n = 1'b1;
        bus_rd(A_CS, rd); check_eq("t6 stat after reset", rd, 32'h0A00);
        check_eq("t6 irq", 32'(irq), 32'd0);
        bus_wr(A_CS, 32'h03);
        bus_wr(A_TX, 32'h96);
        tx_capture(10, 500, bits, waited, got);
        check_eq("t6 got frame", 32'(got), 32'd1);
        check_eq("t6 frame bits", 32'(bits), 32'({1'b1, 8'h96, 1'b0}));
        wait_clk(200);
        bus_wr(A_CS, 32'h0B);
        wait_clk(2);
        check_eq("t6 irq rx", 32'(irq), 32'd1);
        bus_rd(A_RX, rd); check_eq("t6 rxdata", rd, 32'h96);
        wait_clk(2);
        check_eq("t6 irq cleared", 32'(irq), 32'd0);
        bus_wr(A_CS, 32'h07);
        wait_clk(2);
        check_eq("t6 irq txe", 32'(irq), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
